// File: rtl/pam_pkg.sv
// pam_pkg: shared types and constants for the PAM slot scheduler.
//
// Contents:
//   state_t  - scheduler FSM states.
//              GRANT is decoded in the slot-start cycle itself. It lets the
//              arbitration and the slot start share one cycle, so state_q
//              goes straight from the slot-start cycle to MUL or WAIT.
//   DW_DEF   - default sample/amplitude width.
//   PW_DEF   - default period/width counter width.
//   OVR_MAX  - saturation value of the optional overrun counter.
package pam_pkg;

  localparam int DW_DEF  = 16;
  localparam int PW_DEF  = 8;
  localparam int OVR_MAX = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    MUL   = 3'd2,
    EMIT  = 3'd3,
    WAIT  = 3'd4
  } state_t;

endpackage

// File: rtl/pam_rr_arbiter.sv
// pam_rr_arbiter: combinational round-robin picker.
//
// The search starts at the channel after 'last' and wraps. The first
// requesting channel found wins.
//
// Ports:
//   req   in  NCH  per-channel request
//   last  in  CW   most recently granted channel
//   grant out NCH  one-hot winner (all zero when req == 0)
//   idx   out CW   index of the winner (0 when req == 0)
module pam_rr_arbiter
  import pam_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(last) + k) % NCH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = CW'(cand);
      end
    end
  end

endmodule

// File: rtl/pam_slot_scheduler.sv
// pam_slot_scheduler: time-division scheduler for the shared PAM multiplier.
//
// What the block does:
//   - Generates a pulse train from 'period' and 'width'.
//   - Grants one requesting channel per slot, in round-robin order.
//   - Multiplies the granted sample by 'amp'.
//   - Presents the product on a valid/ready stream.
//   - Drives pam_level with the product while the pulse is high, else 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              scheduler enable
//   period, width   slot length and pulse-high cycles (PW bits)
//   amp             unsigned amplitude (DW bits)
//   req             per-channel sample request (NCH bits)
//   sample          packed samples; channel i at [i*DW +: DW]
//   ack             one-hot, one-cycle sample-taken strobe
//   out_valid, out_ready, out_data, out_ch
//                   product stream and the channel of the product
//   pulse           registered pulse gate
//   pam_level       pulse ? held product : 0 (registered)
//
// Optional feature (macro PAM_SCHED_OVERRUN_CNT_EN):
//   Adds output overrun_cnt [7:0]. It counts slots lost to an unaccepted
//   product and saturates at OVR_MAX.
module pam_slot_scheduler
  import pam_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = DW_DEF,
  parameter int PW  = PW_DEF,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PW-1:0]     period,
  input  logic [PW-1:0]     width,
  input  logic [DW-1:0]     amp,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] sample,
  output logic [NCH-1:0]    ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_data,
  output logic [CW-1:0]     out_ch,
  output logic              pulse,
  output logic [2*DW-1:0]   pam_level
`ifdef PAM_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_cnt
`endif
);

  state_t          state_q, state_d, state_cur;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   last_q, last_d;
  logic [DW-1:0]   sample_lat_q, sample_lat_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            out_valid_q, out_valid_d;
  logic [2*DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic            pulse_q, pulse_d;
  logic [2*DW-1:0] pam_level_q, pam_level_d;

  logic [NCH-1:0]  grant_oh;
  logic [CW-1:0]   grant_idx;
  logic [2*DW-1:0] prod;
  logic            run;
  logic            cnt_zero;
  logic            accept;
  logic            pending;
  logic            slot_start;
  logic            grant_fire;

  pam_rr_arbiter #(
    .NCH(NCH),
    .CW (CW)
  ) u_arb (
    .req  (req),
    .last (last_q),
    .grant(grant_oh),
    .idx  (grant_idx)
  );

  assign run      = en && (period >= PW'(2));
  assign cnt_zero = (cnt_q == '0);
  assign accept   = out_valid_q && out_ready;
  assign pending  = out_valid_q && !out_ready;
  assign prod     = (2*DW)'(sample_lat_q) * (2*DW)'(amp);

  // A slot start is honoured only when no product is left stuck.
  // An accept in the same cycle frees the output, so the slot is still
  // granted.
  assign slot_start = run && cnt_zero && !pending &&
                      (state_q == IDLE || state_q == WAIT || state_q == EMIT);
  assign state_cur  = slot_start ? GRANT : state_q;
  assign grant_fire = (state_cur == GRANT) && (|req);

  // Slot counter: wraps at period-1 and is held at zero when not running.
  // The >= compare also handles a period that shrinks mid-slot.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q >= period - PW'(1)) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_cur;
    case (state_cur)
      IDLE:    if (pending) state_d = EMIT;
      GRANT:   state_d = (|req) ? MUL : WAIT;
      MUL:     state_d = EMIT;
      EMIT:    if (accept) state_d = WAIT;
      WAIT:    state_d = WAIT;
      default: state_d = IDLE;
    endcase
    if (!run) state_d = IDLE;
  end

  // Datapath updates. A product already in MUL still lands if en drops;
  // it then waits in out_data until it is accepted.
  always_comb begin
    ack_d        = '0;
    sample_lat_d = sample_lat_q;
    last_d       = last_q;
    out_ch_d     = out_ch_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready;
    if (grant_fire) begin
      ack_d        = grant_oh;
      sample_lat_d = sample[grant_idx*DW +: DW];
      last_d       = grant_idx;
      out_ch_d     = grant_idx;
    end
    if (state_q == MUL) begin
      out_data_d  = prod;
      out_valid_d = 1'b1;
    end
    pulse_d     = run && (cnt_q < width);
    pam_level_d = pulse_d ? out_data_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      last_q       <= CW'(NCH - 1);
      sample_lat_q <= '0;
      ack_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      pulse_q      <= 1'b0;
      pam_level_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      sample_lat_q <= sample_lat_d;
      ack_q        <= ack_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      pulse_q      <= pulse_d;
      pam_level_q  <= pam_level_d;
    end
  end

`ifdef PAM_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic       overrun;

  // An overrun is a slot start that arrives while a product is still
  // unaccepted. That slot is dropped.
  assign overrun = run && cnt_zero && pending &&
                   (state_q == IDLE || state_q == EMIT);

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun && ovr_cnt_q != 8'(OVR_MAX)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_cnt_q <= '0;
    else     ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign pulse     = pulse_q;
  assign pam_level = pam_level_q;

endmodule

// File: tb/tb_pam_slot_scheduler.sv
// tb_pam_slot_scheduler: self-checking bench for pam_slot_scheduler.
// Expected grants and products are queued when stimulus is applied and
// popped as ack strobes and accepted outputs appear.
module tb_pam_slot_scheduler;
  import pam_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int PW  = 8;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PW-1:0]     period;
  logic [PW-1:0]     width;
  logic [DW-1:0]     amp;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] sample;
  logic [NCH-1:0]    ack;
  logic              out_valid;
  logic              out_ready;
  logic [2*DW-1:0]   out_data;
  logic [CW-1:0]     out_ch;
  logic              pulse;
  logic [2*DW-1:0]   pam_level;
`ifdef PAM_SCHED_OVERRUN_CNT_EN
  logic [7:0]        overrun_cnt;
`endif

  typedef struct packed {
    logic [CW-1:0]   ch;
    logic [2*DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   ack_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mcnt  = 0;
  logic exp_pulse = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  pam_slot_scheduler #(.NCH(NCH), .DW(DW), .PW(PW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .period   (period),
    .width    (width),
    .amp      (amp),
    .req      (req),
    .sample   (sample),
    .ack      (ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .pulse    (pulse),
    .pam_level(pam_level)
`ifdef PAM_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  // One clock. Inputs are read before the edge and outputs become
  // visible 1 time unit after it. The reference slot counter and the
  // expected pulse advance with the clock.
  task automatic tick();
    logic run_now;
    int   ncnt;
    logic npulse;
    run_now = en && (period >= 2);
    if (rst || !run_now) ncnt = 0;
    else                 ncnt = (mcnt >= int'(period) - 1) ? 0 : mcnt + 1;
    npulse = !rst && run_now && (mcnt < int'(width));
    @(posedge clk);
    #1;
    mcnt      = rst ? 0 : ncnt;
    exp_pulse = npulse;
    cyc++;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    ack_q.delete();
  endtask

  task automatic push_exp(input int ch, input logic [2*DW-1:0] data);
    exp_t e;
    e.ch   = CW'(ch);
    e.data = data;
    ack_q.push_back(ch);
    sb_q.push_back(e);
  endtask

  function automatic logic [2*DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    return wa * wb;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; period = 8'd10; width = 8'd3; amp = '0;
    req = '0; sample = '0; out_ready = 1'b0;
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (ack !== 4'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0000", ack); end
    total++; if (pulse !== 1'b0 || pam_level !== '0) begin bad++; $display("[TB] FAIL reset_pulse: pulse=%b level=%h want 0/0", pulse, pam_level); end
    total++; if (out_data !== '0 || out_ch !== '0) begin bad++; $display("[TB] FAIL reset_data: data=%h ch=%0d want 0/0", out_data, out_ch); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d want IDLE", dut.state_q); end
    total++; if (dut.last_q !== 2'd3) begin bad++; $display("[TB] FAIL reset_last: got %0d want 3", dut.last_q); end
    total++; if (dut.cnt_q !== '0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
`ifdef PAM_SCHED_OVERRUN_CNT_EN
    total++; if (overrun_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_ovr: got %0d want 0", overrun_cnt); end
`endif
  endtask

  task automatic test_pulse_no_req();
    int highs;
    highs = 0;
    do_reset();
    period = 8'd10; width = 8'd3; req = '0; out_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pulse === 1'b1) highs++;
      total++; if (pulse !== exp_pulse) begin bad++; $display("[TB] FAIL pulse_train: cyc=%0d got %b want %b", cyc, pulse, exp_pulse); end
      total++; if (ack !== 4'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_grant: ack=%b valid=%b want 0000/0", ack, out_valid); end
    end
    total++; if (highs != 12) begin bad++; $display("[TB] FAIL pulse_duty: got %0d highs want 12", highs); end
    en = 1'b0;
  endtask

  task automatic test_round_robin();
    int t0, first_valid;
    logic [DW-1:0] s[4];
    do_reset();
    s[0] = 16'd1; s[1] = 16'd2; s[2] = 16'd3; s[3] = 16'd4;
    sample = {s[3], s[2], s[1], s[0]};
    amp = 16'd2; req = 4'b1111; out_ready = 1'b1; period = 8'd10; width = 8'd3; en = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(k % 4, mul(s[k % 4], amp));
    t0 = cyc;
    first_valid = -1;
    for (int i = 0; i < 80 && sb_q.size() != 0; i++) begin
      tick();
      if (ack !== 4'b0) begin
        total++;
        if (ack_q.size() == 0) begin bad++; $display("[TB] FAIL rr_ack: got %b want none", ack); end
        else begin
          int c; logic [NCH-1:0] oh;
          c = ack_q.pop_front(); oh = '0; oh[c] = 1'b1;
          if (ack !== oh) begin bad++; $display("[TB] FAIL rr_ack: got %b want %b", ack, oh); end
        end
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        e = sb_q.pop_front();
        total++; if ({out_ch, out_data} !== e) begin bad++; $display("[TB] FAIL rr_data: got ch=%0d data=%h want ch=%0d data=%h", out_ch, out_data, e.ch, e.data); end
        total++; if (pam_level !== (exp_pulse ? e.data : '0)) begin bad++; $display("[TB] FAIL rr_level: got %h want %h", pam_level, exp_pulse ? e.data : '0); end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL rr_timeout: %0d products missing", sb_q.size()); end
    total++; if (first_valid - t0 != 2) begin bad++; $display("[TB] FAIL rr_latency: got %0d want 2", first_valid - t0); end
    req = '0; en = 1'b0;
  endtask

  task automatic test_rr_pattern();
    do_reset();
    sample = {16'h8001, 16'h0000, 16'hFFFF, 16'h0000};
    amp = 16'hFFFF; req = 4'b1010; out_ready = 1'b1; period = 8'd10; width = 8'd3; en = 1'b1;
    push_exp(1, 32'hFFFE0001);
    push_exp(3, mul(16'h8001, 16'hFFFF));
    push_exp(1, 32'hFFFE0001);
    push_exp(3, mul(16'h8001, 16'hFFFF));
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      tick();
      if (ack !== 4'b0) begin
        total++;
        if (ack_q.size() == 0) begin bad++; $display("[TB] FAIL pat_ack: got %b want none", ack); end
        else begin
          int c; logic [NCH-1:0] oh;
          c = ack_q.pop_front(); oh = '0; oh[c] = 1'b1;
          if (ack !== oh) begin bad++; $display("[TB] FAIL pat_ack: got %b want %b", ack, oh); end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        e = sb_q.pop_front();
        total++; if ({out_ch, out_data} !== e) begin bad++; $display("[TB] FAIL pat_data: got ch=%0d data=%h want ch=%0d data=%h", out_ch, out_data, e.ch, e.data); end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL pat_timeout: %0d products missing", sb_q.size()); end
    req = '0; en = 1'b0;
  endtask

  task automatic test_overrun();
    int acks, valids;
    acks = 0; valids = 0;
    do_reset();
    sample = {16'd4, 16'd3, 16'd2, 16'd1};
    amp = 16'd3; req = 4'b1111; out_ready = 1'b0; period = 8'd10; width = 8'd3; en = 1'b1;
    push_exp(0, 32'd3);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ack !== 4'b0) begin
        acks++;
        total++;
        if (ack_q.size() == 0) begin bad++; $display("[TB] FAIL ovr_ack: got %b want none", ack); end
        else begin
          int c; logic [NCH-1:0] oh;
          c = ack_q.pop_front(); oh = '0; oh[c] = 1'b1;
          if (ack !== oh) begin bad++; $display("[TB] FAIL ovr_ack: got %b want %b", ack, oh); end
        end
      end
      if (out_valid === 1'b1) begin
        valids++;
        total++; if (out_data !== 32'd3 || out_ch !== 2'd0) begin bad++; $display("[TB] FAIL ovr_hold: got ch=%0d data=%h want 0/3", out_ch, out_data); end
      end
    end
    total++; if (acks != 1) begin bad++; $display("[TB] FAIL ovr_ack_count: got %0d want 1", acks); end
    total++; if (valids != 29) begin bad++; $display("[TB] FAIL ovr_valid_held: got %0d cycles want 29", valids); end
`ifdef PAM_SCHED_OVERRUN_CNT_EN
    total++; if (overrun_cnt !== 8'd2) begin bad++; $display("[TB] FAIL ovr_count: got %0d want 2", overrun_cnt); end
`endif
    // Accept lands on a slot-start cycle: that slot must still be granted.
    out_ready = 1'b1;
    push_exp(1, 32'd6);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      if (ack !== 4'b0) begin
        total++;
        if (ack_q.size() == 0) begin bad++; $display("[TB] FAIL ovr_ack2: got %b want none", ack); end
        else begin
          int c; logic [NCH-1:0] oh;
          c = ack_q.pop_front(); oh = '0; oh[c] = 1'b1;
          if (ack !== oh) begin bad++; $display("[TB] FAIL ovr_ack2: got %b want %b", ack, oh); end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        e = sb_q.pop_front();
        total++; if ({out_ch, out_data} !== e) begin bad++; $display("[TB] FAIL ovr_data: got ch=%0d data=%h want ch=%0d data=%h", out_ch, out_data, e.ch, e.data); end
      end
      if (sb_q.size() != 0) tick();
    end
    total++; if (sb_q.size() != 0 || ack_q.size() != 0) begin bad++; $display("[TB] FAIL ovr_timeout: %0d products %0d acks missing", sb_q.size(), ack_q.size()); end
`ifdef PAM_SCHED_OVERRUN_CNT_EN
    total++; if (overrun_cnt !== 8'd2) begin bad++; $display("[TB] FAIL ovr_count_after: got %0d want 2", overrun_cnt); end
`endif
    req = '0; en = 1'b0;
  endtask

  task automatic test_boundaries();
    int valids;
    valids = 0;
    do_reset();
    sample = {16'd4, 16'd3, 16'd2, 16'd1};
    amp = 16'd2; req = 4'b1111; out_ready = 1'b1; period = 8'd10; width = 8'd0; en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid === 1'b1) valids++;
      total++; if (pulse !== 1'b0 || pam_level !== '0) begin bad++; $display("[TB] FAIL width0: pulse=%b level=%h want 0/0", pulse, pam_level); end
    end
    total++; if (valids != 3) begin bad++; $display("[TB] FAIL width0_products: got %0d want 3", valids); end
    req = '0; width = 8'd12;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (pulse !== 1'b1) begin bad++; $display("[TB] FAIL width_ge_period: cyc=%0d got %b want 1", cyc, pulse); end
    end
    period = 8'd1;
    for (int i = 0; i < 3; i++) tick();
    total++; if (dut.cnt_q !== '0) begin bad++; $display("[TB] FAIL period1_cnt: got %0d want 0", dut.cnt_q); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("[TB] FAIL period1_state: got %0d want IDLE", dut.state_q); end
    total++; if (pulse !== 1'b0) begin bad++; $display("[TB] FAIL period1_pulse: got %b want 0", pulse); end
    period = 8'd10; en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    sample = {16'd4, 16'd3, 16'd2, 16'd1};
    amp = 16'd2; req = 4'b1111; out_ready = 1'b0; period = 8'd10; width = 8'd3; en = 1'b1;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin tick(); waited++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_emit: valid=%b want 1", out_valid); end
    tick();
    total++; if (dut.state_q !== EMIT) begin bad++; $display("[TB] FAIL mid_state: got %0d want EMIT", dut.state_q); end
    rst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== '0 || ack !== 4'b0) begin bad++; $display("[TB] FAIL mid_reset_out: valid=%b data=%h ack=%b want 0/0/0000", out_valid, out_data, ack); end
    total++; if (dut.state_q !== IDLE || dut.last_q !== 2'd3) begin bad++; $display("[TB] FAIL mid_reset_state: state=%0d last=%0d want IDLE/3", dut.state_q, dut.last_q); end
    rst = 1'b0; out_ready = 1'b1;
    push_exp(0, 32'd2);
    for (int i = 0; i < 15 && sb_q.size() != 0; i++) begin
      tick();
      if (ack !== 4'b0) begin
        total++;
        if (ack_q.size() == 0) begin bad++; $display("[TB] FAIL mid_ack: got %b want none", ack); end
        else begin
          int c; logic [NCH-1:0] oh;
          c = ack_q.pop_front(); oh = '0; oh[c] = 1'b1;
          if (ack !== oh) begin bad++; $display("[TB] FAIL mid_ack: got %b want %b", ack, oh); end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        e = sb_q.pop_front();
        total++; if ({out_ch, out_data} !== e) begin bad++; $display("[TB] FAIL mid_data: got ch=%0d data=%h want ch=%0d data=%h", out_ch, out_data, e.ch, e.data); end
      end
    end
    total++; if (sb_q.size() != 0 || ack_q.size() != 0) begin bad++; $display("[TB] FAIL mid_timeout: %0d products %0d acks missing", sb_q.size(), ack_q.size()); end
    req = '0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pulse_no_req();
    test_round_robin();
    test_rr_pattern();
    test_overrun();
    test_boundaries();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
